clarvi_soc_button_pio: RTL and testbench
========================================

# clarvi_soc_button_pio

Avalon-MM slave input PIO for the CLARVI SoC: it samples the board push-buttons/switches, synchronises and debounces each bit, and latches qualifying edges into an edge-capture register with a per-bit interrupt mask. It sits on the processor data bus beside the output PIOs and drives a level interrupt to the core. Software reads it to poll the current input state and clears captured edges by writing ones.

## Interface
- WIDTH, 4: number of input bits (1..32).
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before a bit's debounced level changes (>= 1).
- EDGE_RISING, 1: 1 = capture debounced 0->1 transitions; 0 = capture 1->0.
- INIT_LEVEL, {WIDTH{1'b1}}: reset value of synchroniser and debounced registers (matches idle level of active-low buttons).

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational, read latency 0.
- in_port  in  WIDTH  raw asynchronous inputs.
- irq  out  1  level interrupt, active-high.

## Operation
- Register map: 0 = DATA (RO, debounced levels); 1 = IRQ_MASK (RW, WIDTH bits); 2 = reserved (reads 0, writes ignored); 3 = EDGE_CAPTURE (read; write-1-to-clear).
- Write accepted when chipselect && !write_n; writes to 0 and 2 have no effect.
- readdata = selected register zero-extended to 32 bits; bits [31:WIDTH] always 0; independent of chipselect.
- Synchroniser: two flops per bit (sync1, sync2).
- Debouncer per bit: counter cnt, width clog2(DEBOUNCE_CYCLES) (min 1).
  - sync2 == deb: cnt <= 0.
  - sync2 != deb and cnt == DEBOUNCE_CYCLES-1: deb <= sync2, cnt <= 0.
  - otherwise: cnt <= cnt + 1.
  - Any glitch back to deb level before the count completes restarts the count.
- Edge detect: edge[i] = deb_next[i] != deb[i] in the configured direction; sets EDGE_CAPTURE[i] on the same clock deb updates.
- EDGE_CAPTURE[i] clears on write to address 3 with writedata[i]=1; set and clear on the same edge: set wins.
- irq = |(EDGE_CAPTURE & IRQ_MASK), from registers only (no combinational path from bus inputs).

## Timing
- Reset values: sync1, sync2, deb = INIT_LEVEL; cnt = 0; IRQ_MASK = 0; EDGE_CAPTURE = 0; irq = 0; readdata = 0 at address 1/2/3, INIT_LEVEL at address 0.
- Latency: in_port stable-changed before clock edge 1 -> sync2 changes at edge 2 -> deb changes and EDGE_CAPTURE sets at edge DEBOUNCE_CYCLES+2 -> irq high the same cycle if masked in.
- IRQ_MASK write takes effect on irq the cycle after the write edge.
- Clearing write: irq falls the cycle after the write edge unless another masked capture bit remains or a new edge sets on that edge.
- Reset asserted mid-count: all state returns to reset values immediately; no edge is captured on deassertion unless in_port differs from INIT_LEVEL for the full debounce period afterwards.

## Test plan
- Reset, WIDTH=4, DEBOUNCE_CYCLES=4, INIT_LEVEL=4'hF: read addr 0 -> 0x0000000F, addr 1/2/3 -> 0, irq=0.
- EDGE_RISING=0, drive in_port[0]=0 steady: DATA bit0 and EDGE_CAPTURE bit0 change at edge 6 after input change (exactly, not 5); with IRQ_MASK=0x1, irq=1 same cycle.
- Pulse in_port[1] low for 3 cycles then high: DATA stays 0xF, EDGE_CAPTURE stays 0, irq stays 0.
- Captured bits 0 and 2, mask 0x5: write 0x1 to addr 3 -> EDGE_CAPTURE=0x4, irq stays 1; write 0x4 -> 0x0, irq=0 next cycle.
- Clear write to bit 0 on the same edge a new bit-0 edge completes debounce -> EDGE_CAPTURE bit0 remains 1.
- Assert reset mid-debounce with in_port=0x0 then release: DATA=0xF immediately, falls to 0x0 only DEBOUNCE_CYCLES+2 cycles after release; writes to addr 0/2 never alter any read value.

Source files
------------

// File: rtl/clarvi_soc_button_pio_if.sv
// Avalon-MM slave bus bundle for the CLARVI button/switch input PIO.
// Read data is combinational (zero read latency).
interface clarvi_soc_button_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/clarvi_soc_button_pio.sv
// Input PIO: per-bit two-flop synchroniser and debouncer, edge capture with
// write-1-to-clear, per-bit interrupt mask and a level interrupt to the core.
module clarvi_soc_button_pio #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter bit               EDGE_RISING     = 1'b1,
  parameter logic [WIDTH-1:0] INIT_LEVEL      = {WIDTH{1'b1}}
) (
  input  logic                     clk,
  input  logic                     reset,
  clarvi_soc_button_pio_if.slave   bus,
  input  logic [WIDTH-1:0]         in_port,
  output logic                     irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] deb_q,   deb_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] mask_q,  mask_d;
  logic [WIDTH-1:0] cap_q,   cap_d;

  logic             wr_s;
  logic [WIDTH-1:0] wdata_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] edge_s;
  logic [31:0]      readdata_s;

  assign wr_s    = bus.chipselect & ~bus.write_n;
  assign wdata_s = bus.writedata[WIDTH-1:0];

  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
  end

  // A bit's level only moves after DEBOUNCE_CYCLES consecutive disagreeing
  // samples; any sample matching the current level restarts the count.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = CNT_ZERO;
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = CNT_ZERO;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_comb begin
    edge_s = {WIDTH{1'b0}};
    if (EDGE_RISING) begin
      edge_s = deb_d & ~deb_q;
    end else begin
      edge_s = ~deb_d & deb_q;
    end
  end

  // Set takes priority over a simultaneous write-1-to-clear.
  always_comb begin
    mask_d = mask_q;
    clr_s  = {WIDTH{1'b0}};
    if (wr_s && (bus.address == ADDR_MASK)) begin
      mask_d = wdata_s;
    end else begin
      mask_d = mask_q;
    end
    if (wr_s && (bus.address == ADDR_EDGE)) begin
      clr_s = wdata_s;
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
    cap_d = (cap_q & ~clr_s) | edge_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= INIT_LEVEL;
      sync2_q <= INIT_LEVEL;
      deb_q   <= INIT_LEVEL;
      mask_q  <= {WIDTH{1'b0}};
      cap_q   <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Zero-latency read path, independent of chipselect; unused bits read 0.
  always_comb begin
    readdata_s = 32'd0;
    case (bus.address)
      ADDR_DATA: readdata_s[WIDTH-1:0] = deb_q;
      ADDR_MASK: readdata_s[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata_s[WIDTH-1:0] = cap_q;
      default:   readdata_s = 32'd0;
    endcase
  end

  assign bus.readdata = readdata_s;
  assign irq          = |(cap_q & mask_q);

endmodule

// File: tb/tb_clarvi_soc_button_pio.sv
// Directed bench for the button PIO: WIDTH=4, DEBOUNCE_CYCLES=4, falling-edge
// capture, idle-high inputs.
module tb_clarvi_soc_button_pio;

  logic       clk;
  logic       reset;
  logic [3:0] in_port;
  logic       irq;
  int         checks;
  int         errors;
  logic [31:0] rd;

  clarvi_soc_button_pio_if bus_if ();

  clarvi_soc_button_pio #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (4),
    .EDGE_RISING     (1'b0),
    .INIT_LEVEL      (4'hF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .in_port (in_port),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus_if.address = a;
    #1;
    d = bus_if.readdata;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    in_port = 4'hF;
    bus_if.address    = 2'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 32'd0;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state
    bus_read(2'd0, rd); check("rst_data", rd, 32'h0000000F);
    bus_read(2'd1, rd); check("rst_mask", rd, 32'h0);
    bus_read(2'd2, rd); check("rst_rsvd", rd, 32'h0);
    bus_read(2'd3, rd); check("rst_edge", rd, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);

    bus_write(2'd1, 32'hFFFF_FFF1);
    bus_read(2'd1, rd); check("mask_rd", rd, 32'h1);
    check("mask_irq0", {31'd0, irq}, 32'h0);

    // Bit 0 falls: settles at exactly the sixth edge after the change
    in_port = 4'hE;
    tick(5);
    bus_read(2'd0, rd); check("lat5_data", rd, 32'hF);
    bus_read(2'd3, rd); check("lat5_edge", rd, 32'h0);
    check("lat5_irq", {31'd0, irq}, 32'h0);
    tick(1);
    bus_read(2'd0, rd); check("lat6_data", rd, 32'hE);
    bus_read(2'd3, rd); check("lat6_edge", rd, 32'h1);
    check("lat6_irq", {31'd0, irq}, 32'h1);

    // Three-cycle glitch on bit 1 is rejected
    in_port = 4'hC;
    tick(3);
    in_port = 4'hE;
    tick(8);
    bus_read(2'd0, rd); check("glitch_data", rd, 32'hE);
    bus_read(2'd3, rd); check("glitch_edge", rd, 32'h1);

    // Bits 0 and 2 captured, selective clears
    in_port = 4'hA;
    tick(8);
    bus_read(2'd3, rd); check("cap_02", rd, 32'h5);
    bus_write(2'd1, 32'h5);
    check("irq_mask5", {31'd0, irq}, 32'h1);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, rd); check("clr0_edge", rd, 32'h4);
    check("clr0_irq", {31'd0, irq}, 32'h1);
    bus_write(2'd3, 32'h4);
    bus_read(2'd3, rd); check("clr2_edge", rd, 32'h0);
    check("clr2_irq", {31'd0, irq}, 32'h0);

    // Rising edges are not captured in falling mode
    in_port = 4'hF;
    tick(8);
    bus_read(2'd0, rd); check("rise_data", rd, 32'hF);
    bus_read(2'd3, rd); check("rise_edge", rd, 32'h0);

    // Clear on the same edge a new capture sets: set wins
    in_port = 4'hE;
    tick(5);
    bus_write(2'd3, 32'h1);
    bus_read(2'd0, rd); check("race_data", rd, 32'hE);
    bus_read(2'd3, rd); check("race_edge", rd, 32'h1);
    check("race_irq", {31'd0, irq}, 32'h1);
    bus_write(2'd3, 32'hF);
    bus_read(2'd3, rd); check("race_clr", rd, 32'h0);

    // Reset mid-debounce, then writes to DATA and reserved while counting
    in_port = 4'hF;
    tick(8);
    in_port = 4'h0;
    tick(3);
    reset = 1'b1;
    #1;
    bus_read(2'd0, rd); check("mrst_data", rd, 32'hF);
    bus_read(2'd1, rd); check("mrst_mask", rd, 32'h0);
    bus_read(2'd3, rd); check("mrst_edge", rd, 32'h0);
    tick(2);
    reset = 1'b0;
    bus_write(2'd0, 32'h0);
    bus_write(2'd2, 32'hFFFF_FFFF);
    tick(3);
    bus_read(2'd0, rd); check("rel5_data", rd, 32'hF);
    bus_read(2'd2, rd); check("rel5_rsvd", rd, 32'h0);
    bus_read(2'd3, rd); check("rel5_edge", rd, 32'h0);
    tick(1);
    bus_read(2'd0, rd); check("rel6_data", rd, 32'h0);
    bus_read(2'd3, rd); check("rel6_edge", rd, 32'hF);
    check("rel6_irq", {31'd0, irq}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
